// File: rtl/cc_exec_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cc_exec_stage : Y86-64 execute-stage condition codes, Cnd evaluation and
//                 one-entry valid/ready output register.   Rev 1.0
// ----------------------------------------------------------------------------
module cc_exec_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic             set_cc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cnd,
  output logic [3:0]       out_icode,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam logic [3:0] ICODE_CMOV = 4'd2;
  localparam logic [3:0] ICODE_JXX  = 4'd7;

  logic accept;
  logic sign_xor;
  logic cnd_raw;
  logic cnd_used;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sign_xor = cc_sf ^ cc_of;

  // Cnd reads the codes as they stand before this cycle's update.
  always_comb begin
    cnd_raw = 1'b0;
    case (ifun)
      4'd0:    cnd_raw = 1'b1;
      4'd1:    cnd_raw = sign_xor | cc_zf;
      4'd2:    cnd_raw = sign_xor;
      4'd3:    cnd_raw = cc_zf;
      4'd4:    cnd_raw = !cc_zf;
      4'd5:    cnd_raw = !sign_xor;
      4'd6:    cnd_raw = !sign_xor && !cc_zf;
      default: cnd_raw = 1'b0;
    endcase
  end

  assign cnd_used = ((icode == ICODE_CMOV) || (icode == ICODE_JXX)) ? cnd_raw : 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cnd    <= 1'b0;
      out_icode  <= 4'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_cnd    <= cnd_used;
      out_icode  <= icode;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (accept && set_cc) begin
      cc_zf <= (alu_result == '0);
      cc_sf <= alu_result[WIDTH-1];
      cc_of <= alu_overflow;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cc_exec_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cc_exec_stage : directed stimulus, cycle model and literal checks.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_cc_exec_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic        alu_overflow;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic        set_cc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_cnd;
  logic [3:0]  out_icode;
  logic        cc_zf, cc_sf, cc_of;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  cc_exec_stage #(.WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .icode(icode),
    .ifun(ifun), .set_cc(set_cc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_cnd(out_cnd),
    .out_icode(out_icode), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_valid;
  bit [63:0]   m_result;
  bit          m_cnd;
  bit [3:0]    m_icode;
  bit          m_zf, m_sf, m_of;

  // Branch condition table: bit index = {ZF, S}, one row per ifun 0..6.
  function automatic bit cond_of(input bit [3:0] fn, input bit zf, input bit s);
    bit [3:0] row;
    case (fn)
      4'd0: row = 4'b1111;
      4'd1: row = 4'b1110;
      4'd2: row = 4'b1010;
      4'd3: row = 4'b1100;
      4'd4: row = 4'b0011;
      4'd5: row = 4'b0101;
      4'd6: row = 4'b0001;
      default: row = 4'b0000;
    endcase
    return row[{zf, s}];
  endfunction

  always @(posedge clk) begin
    bit rdy, acc, c;
    if (!reset_n) begin
      m_valid = 0; m_result = 0; m_cnd = 0; m_icode = 0;
      m_zf = 1; m_sf = 0; m_of = 0;
    end else begin
      rdy = !flush && (!m_valid || out_ready);
      acc = in_valid && rdy;
      c = (icode == 4'd2 || icode == 4'd7) ? cond_of(ifun, m_zf, m_sf != m_of) : 1'b0;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_result = alu_result; m_cnd = c; m_icode = icode;
      end else if (out_ready) m_valid = 0;
      if (acc && set_cc) begin
        m_zf = (alu_result == 64'd0);
        m_sf = alu_result[63];
        m_of = alu_overflow;
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("mdl_in_ready", {63'd0, in_ready}, {63'd0, !flush && (!m_valid || out_ready)});
      cmp("mdl_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      cmp("mdl_out_result", out_result, m_result);
      cmp("mdl_out_cnd", {63'd0, out_cnd}, {63'd0, m_cnd});
      cmp("mdl_out_icode", {60'd0, out_icode}, {60'd0, m_icode});
      cmp("mdl_cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_zf, m_sf, m_of});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [63:0] r, input bit ov,
                       input bit [3:0] ic, input bit [3:0] fn, input bit sc);
    in_valid = v; alu_result = r; alu_overflow = ov;
    icode = ic; ifun = fn; set_cc = sc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit v, input logic [63:0] r, input bit ov,
                      input bit [3:0] ic, input bit [3:0] fn, input bit sc);
    drive(v, r, ov, ic, fn, sc);
    tick();
  endtask

  task automatic chk_cc(input string name, input bit z, input bit s, input bit o);
    cmp(name, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, z, s, o});
  endtask

  initial begin
    reset_n = 0; flush = 0; out_ready = 1;
    drive(0, 64'd0, 0, 4'd0, 4'd0, 0);
    tick(); tick();
    reset_n = 1;
    #1;
    chk_en = 1;
    chk_cc("reset_cc", 1, 0, 0);
    cmp("reset_out_valid", {63'd0, out_valid}, 64'd0);
    cmp("reset_out_result", out_result, 64'd0);
    cmp("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Clear ZF, then subq giving zero, then jle.
    step(1, 64'd5, 0, 4'd6, 4'd0, 1);
    chk_cc("nonzero_cc", 0, 0, 0);
    step(1, 64'd0, 0, 4'd6, 4'd1, 1);
    chk_cc("subq_zero_cc", 1, 0, 0);
    cmp("opq_cnd_zero", {63'd0, out_cnd}, 64'd0);
    step(1, 64'h55, 0, 4'd7, 4'd1, 0);
    cmp("jle_cnd", {63'd0, out_cnd}, 64'd1);
    cmp("jle_icode", {60'd0, out_icode}, 64'd7);

    // Overflowing subq then jl / jge / cmovg.
    step(1, 64'h8000_0000_0000_001E, 1, 4'd6, 4'd1, 1);
    chk_cc("ovf_cc", 0, 1, 1);
    step(1, 64'h10, 0, 4'd7, 4'd2, 0);
    cmp("jl_cnd", {63'd0, out_cnd}, 64'd0);
    step(1, 64'h11, 0, 4'd7, 4'd5, 0);
    cmp("jge_cnd", {63'd0, out_cnd}, 64'd1);
    step(1, 64'h12, 0, 4'd2, 4'd6, 0);
    cmp("cmovg_cnd", {63'd0, out_cnd}, 64'd1);
    step(1, 64'h13, 0, 4'd7, 4'd4, 0);
    cmp("jne_cnd", {63'd0, out_cnd}, 64'd1);
    step(1, 64'h14, 0, 4'd7, 4'd9, 0);
    cmp("ifun9_cnd", {63'd0, out_cnd}, 64'd0);

    // irmovq: no CC update and no Cnd even with ifun 0.
    step(1, 64'd0, 0, 4'd3, 4'd0, 0);
    chk_cc("irmovq_cc", 0, 1, 1);
    cmp("irmovq_cnd", {63'd0, out_cnd}, 64'd0);
    cmp("irmovq_result", out_result, 64'd0);

    // Backpressure: A held while B waits three cycles.
    step(1, 64'h1, 0, 4'd3, 4'd0, 0);
    drive(1, 64'h2, 0, 4'd3, 4'd0, 0);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp("bp_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      cmp("bp_result_hold", out_result, 64'h1);
      cmp("bp_valid_hold", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1;
    #1;
    cmp("bp_release_ready", {63'd0, in_ready}, 64'd1);
    tick();
    cmp("bp_b_result", out_result, 64'h2);
    cmp("bp_b_valid", {63'd0, out_valid}, 64'd1);

    // Flush while stalled, with a would-be zero result and set_cc.
    out_ready = 0;
    step(1, 64'h77, 0, 4'd6, 4'd0, 0);
    flush = 1;
    drive(1, 64'd0, 0, 4'd6, 4'd0, 1);
    #1;
    cmp("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 0;
    chk_cc("flush_cc", 0, 1, 1);
    cmp("flush_valid", {63'd0, out_valid}, 64'd0);
    cmp("flush_result_hold", out_result, 64'h2);
    out_ready = 1;

    // Full-rate stream with mixed codes.
    for (int i = 0; i < 8; i++)
      step(1, 64'(i) << (i * 8), i[0], 4'((i % 3 == 0) ? 6 : 7), 4'(i), 1'(i % 3 == 0));
    cmp("stream_last", out_result, 64'd7 << 56);

    // Reset mid-transfer discards the held instruction.
    out_ready = 0;
    step(1, 64'hAB, 0, 4'd6, 4'd0, 1);
    reset_n = 0;
    tick();
    reset_n = 1;
    cmp("midreset_valid", {63'd0, out_valid}, 64'd0);
    chk_cc("midreset_cc", 1, 0, 0);
    out_ready = 1;
    step(0, 64'd0, 0, 4'd0, 4'd0, 0);
    step(0, 64'd0, 0, 4'd0, 4'd0, 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cc_exec_stage.md
# cc_exec_stage

Execute-stage condition-code unit for the Y86-64 pipeline, sitting directly downstream of the 64-bit ALU (adder/subtractor/logic). It consumes the ALU result and signed-overflow flag and updates the architectural condition codes ZF/SF/OF for OPq instructions. It evaluates the branch/cmov condition `Cnd` from the current codes and registers result and `Cnd` into a one-entry valid/ready output stage feeding the memory stage.

## Interface
- `WIDTH`, 64, datapath width; 64 is the only supported value.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  ALU result and control are valid this cycle.
- `in_ready`  output  1  stage can accept this cycle.
- `alu_result`  input  WIDTH  ALU output (valE).
- `alu_overflow`  input  1  ALU signed overflow. The subtractor's `borrow` is not used; Y86 has no carry flag.
- `icode`  input  4  instruction code.
- `ifun`  input  4  function code.
- `set_cc`  input  1  this instruction updates the condition codes. Asserted by decode for OPq, icode 6.
- `flush`  input  1  squash: mispredict or exception downstream.
- `out_valid`  output  1  output register holds a live instruction.
- `out_ready`  input  1  memory stage accepts this cycle.
- `out_result`  output  WIDTH  registered `alu_result`.
- `out_cnd`  output  1  registered condition outcome.
- `out_icode`  output  4  registered `icode`.
- `cc_zf`, `cc_sf`, `cc_of`  output  1 each  architectural condition codes.

## Operation
- Handshake:
  - `in_ready = !flush && (!out_valid || out_ready)`.
  - `accept = in_valid && in_ready`.
- On `accept`:
  - `out_result`, `out_icode` and `out_cnd` load.
  - `out_valid` becomes 1.
- If `out_valid && out_ready && !accept`, `out_valid` becomes 0.
- CC update occurs only on `accept && set_cc`:
  - ZF = (`alu_result` == 0)
  - SF = `alu_result[63]`
  - OF = `alu_overflow`
- Cnd uses the CC register value *before* this cycle's update. It is decoded from `ifun`, with S = SF^OF:
  - 0 always: 1
  - 1 le: S|ZF
  - 2 l: S
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !S
  - 6 g: !S & !ZF
  - 7–15: 0
- `out_cnd` = Cnd if `icode` is 2 (cmov) or 7 (jXX), else 0.
- Ordering: CC updates strictly on accept. Instruction k therefore always sees the codes from all earlier accepted instructions; no forwarding is needed.
- Flush:
  - No accept and no CC update that cycle.
  - `out_valid` becomes 0 next edge, regardless of `out_ready`.
  - `out_result`, `out_cnd` and `out_icode` hold.
- Reset has priority over flush and accept. A reset mid-transfer discards the held instruction.

## Timing
- Reset values (edge with `reset_n`=0):
  - `out_valid`=0, `out_result`=0, `out_cnd`=0, `out_icode`=0
  - ZF=1, SF=0, OF=0
  - `in_ready` is combinational: 1 after reset while `flush`=0.
- Latency: 1 cycle from accept to `out_valid`/`out_result`/`out_cnd`. `cc_*` reflect the update in the cycle after accept.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Stall: with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and all outputs hold stable.
- Simultaneous drain and accept (`out_valid && out_ready && accept`): the output is replaced and `out_valid` stays 1.
- `in_ready` depends combinationally on `out_ready` and `flush`. There is no combinational path from `in_valid` to `in_ready`.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles, then release. Required: ZF=1, SF=0, OF=0, `out_valid`=0, `out_result`=0, `in_ready`=1.
- **Subq equal then jle:**
  - Cycle n: `alu_result`=0, `alu_overflow`=0, `set_cc`=1, icode 6, accept.
  - Cycle n+1: icode 7, ifun 1.
  - Required: ZF=1, SF=0, OF=0 after n; `out_cnd`=1 for the jle.
- **Overflow then jl:**
  - `alu_result`=0x8000_0000_0000_001E, `alu_overflow`=1, `set_cc`=1. This is the subq of 0x7FFF…FFFF − 0xFFFF…FFE1.
  - Then icode 7, ifun 2.
  - Required: ZF=0, SF=1, OF=1, S=0, so `out_cnd`=0. A following ifun 5 (ge) gives `out_cnd`=1.
- **No set_cc:** irmovq (icode 3) with `alu_result`=0 after the previous CC state. Required: CC unchanged; `out_cnd`=0 (icode not 2/7).
- **Backpressure:**
  - Accept A=0x1, then hold `out_ready`=0 for 3 cycles while `in_valid`=1 with B=0x2.
  - Required: `in_ready`=0 and `out_result`=0x1 stable.
  - Then set `out_ready`=1. Required: B accepted that cycle, `out_result`=0x2 next cycle, `out_valid` stays 1.
- **Flush:**
  - Assert `flush` with `in_valid`=1, `set_cc`=1, `alu_result`=0 while CC is ZF=0.
  - Required: no accept, ZF stays 0, `out_valid`=0 next cycle.
